// File: rtl/cabin_call_pulse_gen_if.sv
// Cabin call button bundle: raw button in, debounced level and event flags out.
interface cabin_call_pulse_gen_if;
   logic btn_raw;
   logic en_pulse;
   logic btn_level;
   logic busy;
   logic drop_pulse;

   // Button source / event consumer side
   modport master (
      output btn_raw,
      input  en_pulse,
      input  btn_level,
      input  busy,
      input  drop_pulse
   );

   // Debouncer side
   modport slave (
      input  btn_raw,
      output en_pulse,
      output btn_level,
      output busy,
      output drop_pulse
   );
endinterface

// File: rtl/cabin_call_pulse_gen.sv
// Cabin call button debouncer: synchronizes a bouncing button, qualifies
// level changes over DEBOUNCE_CYCLES stable samples, and emits one enable
// pulse per accepted press, suppressing presses inside a holdoff window.
module cabin_call_pulse_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLDOFF_CYCLES  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   cabin_call_pulse_gen_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   localparam logic [7:0] DB_LIM  = 8'(DEBOUNCE_CYCLES);
   localparam logic [7:0] HO_LOAD = 8'(HOLDOFF_CYCLES);

   state_t     state, state_nxt;
   logic       sync_q, s_btn;
   logic [7:0] db_cnt, db_nxt, db_inc;
   logic [7:0] ho_cnt, ho_nxt;
   logic       accept;
   logic       level_q, level_nxt;
   logic       en_q, en_nxt;
   logic       drop_q, drop_nxt;
   logic       busy_q, busy_nxt;

   // Two-flop synchronizer for the asynchronous button input
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 1'b0;
         s_btn  <= 1'b0;
      end else begin
         sync_q <= bus.btn_raw;
         s_btn  <= sync_q;
      end
   end

   // Next-state, debounce counter, holdoff counter and output flags
   always_comb begin
      state_nxt = state;
      db_nxt    = db_cnt;
      level_nxt = level_q;
      accept    = 1'b0;
      db_inc    = db_cnt + 8'd1;

      case (state)
         IDLE: begin
            db_nxt = '0;
            if (s_btn) begin
               if (DB_LIM == 8'd1) begin
                  state_nxt = HELD;
                  level_nxt = 1'b1;
                  accept    = 1'b1;
               end else begin
                  state_nxt = PRESS_WAIT;
                  db_nxt    = 8'd1;
               end
            end
         end
         PRESS_WAIT: begin
            if (!s_btn) begin
               state_nxt = IDLE;
               db_nxt    = '0;
            end else if (db_inc == DB_LIM) begin
               state_nxt = HELD;
               db_nxt    = '0;
               level_nxt = 1'b1;
               accept    = 1'b1;
            end else begin
               db_nxt = db_inc;
            end
         end
         HELD: begin
            db_nxt = '0;
            if (!s_btn) begin
               if (DB_LIM == 8'd1) begin
                  state_nxt = IDLE;
                  level_nxt = 1'b0;
               end else begin
                  state_nxt = RELEASE_WAIT;
                  db_nxt    = 8'd1;
               end
            end
         end
         RELEASE_WAIT: begin
            if (s_btn) begin
               state_nxt = HELD;
               db_nxt    = '0;
            end else if (db_inc == DB_LIM) begin
               state_nxt = IDLE;
               db_nxt    = '0;
               level_nxt = 1'b0;
            end else begin
               db_nxt = db_inc;
            end
         end
         default: begin
            state_nxt = IDLE;
            db_nxt    = '0;
         end
      endcase

      // An accept only reloads holdoff when the window has fully expired;
      // otherwise the counter keeps draining and the press is flagged dropped.
      en_nxt   = 1'b0;
      drop_nxt = 1'b0;
      ho_nxt   = ho_cnt;
      if (accept && (ho_cnt == '0)) begin
         en_nxt = 1'b1;
         ho_nxt = HO_LOAD;
      end else begin
         if (accept) begin
            drop_nxt = 1'b1;
         end
         if (ho_cnt != '0) begin
            ho_nxt = ho_cnt - 8'd1;
         end
      end
      busy_nxt = (ho_nxt != '0);
   end

   // State and registered outputs; reset overrides every pending event
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         db_cnt  <= '0;
         ho_cnt  <= '0;
         level_q <= 1'b0;
         en_q    <= 1'b0;
         drop_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         db_cnt  <= db_nxt;
         ho_cnt  <= ho_nxt;
         level_q <= level_nxt;
         en_q    <= en_nxt;
         drop_q  <= drop_nxt;
         busy_q  <= busy_nxt;
      end
   end

   assign bus.en_pulse   = en_q;
   assign bus.btn_level  = level_q;
   assign bus.busy       = busy_q;
   assign bus.drop_pulse = drop_q;

endmodule
